tt_sweep_capture: RTL
=====================

// Module: tt_sweep_capture
// PURPOSE
//  Upstream driver and downstream collector for one 7-input single-output function block.
//  Walks all 128 input combinations into the function under test and captures its output into a 128-bit truth table.
//  Compares the captured table against an expected table.
//  Used for on-chip signature checking of the synthesised function library.
//  Bit ordering: truth-table bit i = f(x = i), x[0] = LSB, table printed MSB (i=127) first.
// PARAMETERS
//  N_IN     7   number of function inputs; table width is 2**N_IN
//  DUT_LAT  0   clock cycles from x change to valid f_in (0 = combinational function)
// PORTS
//  clk             in   1    single clock, rising edge
//  rst_n           in   1    synchronous, active-low reset
//  start           in   1    request a sweep; accepted only when busy=0
//  expected        in   128  golden table; latched on accepted start
//  x               out  7    stimulus to function inputs x0..x6
//  f_in            in   1    function output
//  busy            out  1    high from accepted start until done
//  done            out  1    one-cycle pulse when results are valid
//  tt              out  128  captured truth table; held until next accepted start
//  match           out  1    tt == latched expected; valid from done onward
//  mismatch_cnt    out  8    number of differing bits, 0..128
//  first_fail_idx  out  7    lowest index i with tt[i] != expected[i]
//  first_fail_vld  out  1    at least one mismatch seen
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge) sets all outputs to 0 and the FSM to IDLE. This includes abort mid-sweep, with no partial result kept.
//  FSM states: IDLE -> DRIVE -> DRAIN -> DONE -> IDLE.
//   IDLE:  start=1 latches expected; clears tt, mismatch_cnt and first_fail_*; sets idx=0, busy=1; goes to DRIVE.
//   DRIVE: x=idx; idx increments each cycle. At idx=127, go to DRAIN if DUT_LAT>0, else DONE.
//   DRAIN: wait DUT_LAT cycles; x holds at 127.
//   DONE:  done=1 for one cycle, busy=0, match registered; returns to IDLE.
//  Sampling:
//   - A DUT_LAT-deep delay line carries (valid, idx).
//   - On each delayed-valid cycle: tt[d_idx] <= f_in. If f_in != expected[d_idx], mismatch_cnt increments.
//   - First such d_idx sets first_fail_idx and first_fail_vld.
//  Latency: accepted start -> done = 1 + 128 + DUT_LAT cycles.
//  start while busy=1 is ignored (no restart). start in the DONE cycle is ignored.
//  start=1 held continuously gives back-to-back sweeps separated by one IDLE cycle.
//  x is 0 in IDLE. The index counter saturates and must not wrap past 127 within one sweep.
//  mismatch_cnt is 8 bits so that 128 is representable and cannot overflow.
//  match = (mismatch_cnt == 0), registered on entry to DONE.
// STRUCTURE
//  Shared package tt_pkg:
//   - N_IN, TT_W = 2**N_IN.
//   - typedef tt_t (logic [TT_W-1:0]).
//   - typedef idx_t (logic [N_IN-1:0]).
//   - FSM state enum.
//  Sub-module tt_lat_pipe:
//   - Parameterised DUT_LAT-stage shift register of {valid, idx_t}.
//   - Synchronous active-low reset clears valid bits.
//   - DUT_LAT=0 is a wire-through.
//  Top holds the FSM, index counter, capture register, and compare/count logic.
// TESTING
//  1. Combinational DUT = target 0xfee8eee0fae8e8a0fae8e8a0f888e880, expected same:
//     tt equals the target, match=1, mismatch_cnt=0, done exactly 129 cycles after start.
//  2. Constant-0 DUT, same expected:
//     tt=0, match=0, mismatch_cnt = popcount(expected), first_fail_idx=7 (bit 7 is the lowest set bit, 0x80).
//  3. Same target with bit 5 inverted (fault injection):
//     mismatch_cnt=1, first_fail_idx=5, first_fail_vld=1, match=0.
//  4. DUT_LAT=2 registered version of the target:
//     identical tt, match=1, done 131 cycles after start, x holds 127 during DRAIN.
//  5. rst_n low for 1 cycle when idx=60:
//     all outputs 0 next cycle; a new start then gives a clean full sweep with correct tt.
//  6. start pulsed again at idx=40 and during DONE:
//     ignored; a single done pulse; results unaffected.

Source files
------------

// File: rtl/tt_pkg.sv
// Shared types for the truth-table sweep engine.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tt_pkg;
    localparam int N_IN = 7;
    localparam int TT_W = 2 ** N_IN;

    typedef logic [TT_W-1:0] tt_t;
    typedef logic [N_IN-1:0] idx_t;
    // 8 bits so that a full 128-bit disagreement is representable
    typedef logic [7:0]      cnt_t;

    localparam idx_t IDX_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_DRAIN,
        S_DONE
    } state_e;
endpackage

// File: rtl/tt_sweep_capture_if.sv
// Request/result bundle between the sweep engine and its environment.
// Latency: n/a (wiring only).
// Backpressure: none; start is simply ignored while busy is high.
interface tt_sweep_capture_if;
    logic           start;
    tt_pkg::tt_t    expected;
    tt_pkg::idx_t   x;
    logic           f_in;
    logic           busy;
    logic           done;
    tt_pkg::tt_t    tt;
    logic           match;
    tt_pkg::cnt_t   mismatch_cnt;
    tt_pkg::idx_t   first_fail_idx;
    logic           first_fail_vld;

    // environment side: requests sweeps and hosts the function under test
    modport master (
        output start, expected, f_in,
        input  x, busy, done, tt, match, mismatch_cnt, first_fail_idx, first_fail_vld
    );

    // sweep engine side
    modport slave (
        input  start, expected, f_in,
        output x, busy, done, tt, match, mismatch_cnt, first_fail_idx, first_fail_vld
    );
endinterface

// File: rtl/tt_lat_pipe.sv
// Delay line carrying {valid, idx} alongside the function's own pipeline.
// Latency: DUT_LAT cycles; DUT_LAT=0 is a plain wire-through.
// Backpressure: none; shifts every cycle.
module tt_lat_pipe
    import tt_pkg::*;
#(
    parameter int DUT_LAT = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vld_i,
    input  idx_t idx_i,
    output logic vld_o,
    output idx_t idx_o
);

    generate
        if (DUT_LAT == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign vld_o = vld_i;
            assign idx_o = idx_i;
        end else begin : g_pipe
            logic [DUT_LAT-1:0] vld_q;
            idx_t               idx_q [DUT_LAT];

            // valid bits are cleared on reset so an aborted sweep leaves no stragglers
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    vld_q <= '0;
                end else begin
                    vld_q[0] <= vld_i;
                    for (int i = 1; i < DUT_LAT; i++) begin
                        vld_q[i] <= vld_q[i-1];
                    end
                end
            end

            // index payload needs no reset; it is qualified by the valid bits
            always_ff @(posedge clk) begin
                idx_q[0] <= idx_i;
                for (int i = 1; i < DUT_LAT; i++) begin
                    idx_q[i] <= idx_q[i-1];
                end
            end

            assign vld_o = vld_q[DUT_LAT-1];
            assign idx_o = idx_q[DUT_LAT-1];
        end
    endgenerate

endmodule

// File: rtl/tt_sweep_capture.sv
// Walks all 2**N_IN inputs into a function block, captures its truth table, compares to a golden one.
// Latency: accepted start -> done pulse = 1 + 128 + DUT_LAT cycles.
// Backpressure: none; start is ignored unless idle (busy=0), including the DONE cycle.
module tt_sweep_capture
    import tt_pkg::*;
#(
    parameter int DUT_LAT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    tt_sweep_capture_if.slave bus
);

    localparam cnt_t DRAIN_LAST = cnt_t'((DUT_LAT > 0) ? (DUT_LAT - 1) : 0);

    state_e state_q, state_d;
    idx_t   idx_q, idx_d;
    cnt_t   drain_q, drain_d;
    tt_t    exp_q, exp_d;
    tt_t    tt_q, tt_d;
    cnt_t   cnt_q, cnt_d;
    idx_t   ff_idx_q, ff_idx_d;
    logic   ff_vld_q, ff_vld_d;
    logic   match_q, match_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;

    logic   smp_vld;
    idx_t   smp_idx;

    // index travels with the function's latency so f_in is paired with the x that produced it
    tt_lat_pipe #(.DUT_LAT(DUT_LAT)) u_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .vld_i (state_q == S_DRIVE),
        .idx_i (idx_q),
        .vld_o (smp_vld),
        .idx_o (smp_idx)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state, sweep control, capture and compare
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        drain_d  = drain_q;
        exp_d    = exp_q;
        tt_d     = tt_q;
        cnt_d    = cnt_q;
        ff_idx_d = ff_idx_q;
        ff_vld_d = ff_vld_q;
        match_d  = match_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        // samples arrive in ascending index order, so the first miss is the lowest one
        if (smp_vld) begin
            tt_d[smp_idx] = bus.f_in;
            if (bus.f_in != exp_q[smp_idx]) begin
                cnt_d = cnt_q + 8'd1;
                if (!ff_vld_q) begin
                    ff_vld_d = 1'b1;
                    ff_idx_d = smp_idx;
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    exp_d    = bus.expected;
                    tt_d     = '0;
                    cnt_d    = '0;
                    ff_idx_d = '0;
                    ff_vld_d = 1'b0;
                    match_d  = 1'b0;
                    idx_d    = '0;
                    drain_d  = '0;
                    busy_d   = 1'b1;
                    state_d  = S_DRIVE;
                end
            end
            S_DRIVE: begin
                // counter saturates at the last index rather than wrapping
                if (idx_q == IDX_MAX) begin
                    drain_d = '0;
                    state_d = (DUT_LAT > 0) ? S_DRAIN : S_DONE;
                end else begin
                    idx_d = idx_q + 7'd1;
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + 8'd1;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // the final sample lands on the same edge that enters DONE, so use the updated count
        if (state_d == S_DONE && state_q != S_DONE) begin
            match_d = (cnt_d == '0);
        end
    end

    // datapath and result registers; reset discards any partial sweep
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q    <= '0;
            drain_q  <= '0;
            exp_q    <= '0;
            tt_q     <= '0;
            cnt_q    <= '0;
            ff_idx_q <= '0;
            ff_vld_q <= 1'b0;
            match_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            drain_q  <= drain_d;
            exp_q    <= exp_d;
            tt_q     <= tt_d;
            cnt_q    <= cnt_d;
            ff_idx_q <= ff_idx_d;
            ff_vld_q <= ff_vld_d;
            match_q  <= match_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // stimulus is parked at 0 when not sweeping
    assign bus.x              = (state_q == S_DRIVE || state_q == S_DRAIN) ? idx_q : '0;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.tt             = tt_q;
    assign bus.match          = match_q;
    assign bus.mismatch_cnt   = cnt_q;
    assign bus.first_fail_idx = ff_idx_q;
    assign bus.first_fail_vld = ff_vld_q;

endmodule
